status_uart_tx: RTL
===================

Name: status_uart_tx

Overview:
Serial telemetry transmitter for the industrial monitoring top level. It snapshots the sensor status flags (ir, gas, fire) and the 14-bit event count, packs them into a fixed 5-byte frame, and shifts the frame out on a UART TX line (8N1, LSB first). Frames are sent on a periodic timer and immediately on any new gas or fire alarm. This is the outbound path toward a remote supervisor, complementing the local buzzer, LED and 7-segment outputs.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz.
BAUD, 9600, line rate. DIV = CLK_HZ/BAUD (integer division) cycles per bit; DIV must be at least 2.
PERIOD_CYC, 100_000_000, clock cycles between periodic frames; must be at least 1.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
reset  in  1  asynchronous, active-low reset.
count  in  14  event count, synchronous to clk.
ir  in  1  IR sensor status, asynchronous; 2-FF synchronised internally.
gas_in  in  1  gas alarm, asynchronous; 2-FF synchronised internally.
fire  in  1  fire alarm, asynchronous; 2-FF synchronised internally.
tx  out  1  UART serial output; idles high.
busy  out  1  high from the frame LOAD cycle through the end of the last stop bit.
frame_done  out  1  one-cycle pulse in the cycle after the last stop bit of byte 4 completes.

Behaviour:
- Reset (reset=0, asynchronous): tx=1, busy=0, frame_done=0. Period timer, pending flag, synchronisers and both FSMs are cleared. Reset mid-frame aborts the frame: tx returns high immediately and no partial-frame resume follows.
- Trigger sources:
  - The period timer counts 0..PERIOD_CYC-1 freely and wraps. It raises a trigger in its wrap cycle.
  - A rising edge on synchronised gas_in or fire raises a trigger.
  - All triggers OR into the pending flag.
- Pending flag: set by any trigger, cleared in the frame LOAD cycle. Any number of triggers during busy coalesce into exactly one follow-up frame. A trigger in the same cycle as LOAD sets pending again, so a later frame is still sent.
- Frame FSM states: F_IDLE, F_LOAD, F_SEND, F_WAIT, F_DONE.
  - F_IDLE -> F_LOAD when pending=1.
  - F_LOAD: snapshot count and the synchronised flags, build the 5 bytes, set byte index to 0, assert busy -> F_SEND.
  - F_SEND: issue a start pulse to the byte transmitter with byte[idx] -> F_WAIT.
  - F_WAIT: on byte-done, if idx<4 then idx++ and go to F_SEND; otherwise go to F_DONE.
  - F_DONE: pulse frame_done, drop busy -> F_IDLE.
- Frame bytes (the snapshot is fixed for the whole frame):
  - B0 = 0xA5.
  - B1 = {5'b0, fire, gas, ir}.
  - B2 = {2'b0, count[13:8]}.
  - B3 = count[7:0].
  - B4 = B1 ^ B2 ^ B3.
- Byte transmitter FSM states: T_IDLE, T_START, T_DATA, T_STOP.
  - Each bit is held for exactly DIV cycles.
  - The start bit is 0, followed by data bits 0..7, then one stop bit of 1.
  - byte-done pulses on the last cycle of the stop bit.
  - Bytes in a frame are back-to-back; the inter-byte gap is at most 2 cycles of idle-high.
- Latency:
  - A trigger registered at cycle T puts the FSM in F_LOAD at T+1.
  - tx goes low (start of B0) at T+3.
  - Frame length is 50*DIV cycles plus inter-byte gaps.
- Alarm edge detect runs on the synchronised signals: input change to trigger takes 3 cycles. A level held high does not re-trigger.

Decomposition:
- Shared package status_tx_pkg holds:
  - FRAME_HDR = 8'hA5 and FRAME_LEN = 5.
  - Enum typedefs for the frame FSM and byte FSM states.
  - The flag-byte bit positions (IR=0, GAS=1, FIRE=2).
- Sub-module uart_tx_byte owns the baud counter, shift register and T_* FSM.
  - Ports: clk, reset, start, data[7:0], tx, done.
  - Reusable by other outbound links in the design.

Test Plan:
- Bench uses CLK_HZ=16, BAUD=1 (DIV=16), PERIOD_CYC=2000.
1. Reset, then hold fire=0, gas_in=0, ir=1, count=14'h1234 -> first periodic frame at cycle ~2000 decodes A5 01 12 34 27. Each bit lasts 16 cycles; frame_done pulses once; busy spans the whole frame.
2. Set fire=1, ir=1, count=14'h1234, with the period timer far from wrap -> frame starts 3+3 cycles after the fire edge and decodes A5 05 12 34 23.
3. Raise gas_in, then pulse fire twice mid-frame, all while busy -> exactly one extra frame follows the current one; flags are snapshot at that frame's LOAD.
4. Change count from 0x0001 to 0x3FFF during byte 1 of a frame -> the current frame still carries 00 01. The next frame carries 3F FF with checksum = flags^0x3F^0xFF.
5. Assert reset=0 during byte 2 -> tx=1 and busy=0 in the same cycle with no frame_done. After release, no frame is sent until the next trigger.
6. Hold fire=1 steady for 3 periods -> only periodic frames are sent (one per PERIOD_CYC), with no repeated edge frames.

Source files
------------

// File: rtl/status_tx_pkg.sv
// Shared types and constants for the status telemetry UART link.
// Frame layout: header, flag byte, count high, count low, XOR checksum.
package status_tx_pkg;

  localparam logic [7:0] FRAME_HDR = 8'hA5;
  localparam int         FRAME_LEN = 5;

  // Bit positions inside the flag byte B1
  localparam int FLAG_IR   = 0;
  localparam int FLAG_GAS  = 1;
  localparam int FLAG_FIRE = 2;
  localparam int FLAG_W    = 3;

  typedef enum logic [2:0] {
    F_IDLE,
    F_LOAD,
    F_SEND,
    F_WAIT,
    F_DONE
  } frame_state_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_START,
    T_DATA,
    T_STOP
  } byte_state_t;

  typedef struct packed {
    logic [FLAG_W-1:0] flags;
    logic [13:0]       count;
  } status_snap_t;

  typedef logic [FRAME_LEN-1:0][7:0] frame_t;

  function automatic frame_t build_frame(input status_snap_t s);
    frame_t f;
    f[0] = FRAME_HDR;
    f[1] = {5'b0, s.flags};
    f[2] = {2'b0, s.count[13:8]};
    f[3] = s.count[7:0];
    f[4] = f[1] ^ f[2] ^ f[3];
    return f;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first; each bit is held for DIV clock cycles.
// done is high during the last cycle of the stop bit.
module uart_tx_byte
  import status_tx_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  byte_state_t   st;
  logic [CW-1:0] cnt;
  logic [7:0]    sh;
  logic [2:0]    bitn;
  logic          bit_end;

  assign bit_end = (cnt == CW'(DIV - 1));
  assign done    = (st == T_STOP) && bit_end;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st   <= T_IDLE;
      cnt  <= '0;
      sh   <= '0;
      bitn <= '0;
      tx   <= 1'b1;
    end else begin
      cnt <= (st == T_IDLE || bit_end) ? '0 : cnt + 1'b1;
      case (st)
        T_IDLE: begin
          if (start) begin
            sh <= data;
            tx <= 1'b0;
            st <= T_START;
          end
        end
        T_START: begin
          if (bit_end) begin
            tx   <= sh[0];
            bitn <= '0;
            st   <= T_DATA;
          end
        end
        T_DATA: begin
          // sh[0] is always the bit currently on the line
          if (bit_end) begin
            if (bitn == 3'd7) begin
              tx <= 1'b1;
              st <= T_STOP;
            end else begin
              tx   <= sh[1];
              sh   <= {1'b0, sh[7:1]};
              bitn <= bitn + 1'b1;
            end
          end
        end
        T_STOP: begin
          if (bit_end) st <= T_IDLE;
        end
        default: st <= T_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/status_uart_tx.sv
// Telemetry frame sender: snapshots sensor flags and event count into a
// 5-byte frame, sent periodically and on each new gas/fire alarm edge.
module status_uart_tx
  import status_tx_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int PERIOD_CYC = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] count,
  input  logic        ir,
  input  logic        gas_in,
  input  logic        fire,
  output logic        tx,
  output logic        busy,
  output logic        frame_done
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int TW  = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;

  logic [FLAG_W-1:0] flag_raw, flag_s1, flag_s;
  logic [1:0]        alarm_now, alarm_d;
  logic              alarm_rise;

  assign flag_raw[FLAG_IR]   = ir;
  assign flag_raw[FLAG_GAS]  = gas_in;
  assign flag_raw[FLAG_FIRE] = fire;
  assign alarm_now  = {flag_s[FLAG_FIRE], flag_s[FLAG_GAS]};
  assign alarm_rise = |(alarm_now & ~alarm_d);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flag_s1 <= '0;
      flag_s  <= '0;
      alarm_d <= '0;
    end else begin
      flag_s1 <= flag_raw;
      flag_s  <= flag_s1;
      alarm_d <= alarm_now;
    end
  end

  logic [TW-1:0] tmr;
  logic          tmr_wrap;
  logic          trig;

  assign tmr_wrap = (tmr == TW'(PERIOD_CYC - 1));
  assign trig     = tmr_wrap | alarm_rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmr <= '0;
    else        tmr <= tmr_wrap ? '0 : tmr + 1'b1;
  end

  frame_state_t fst;
  frame_t       frm;
  status_snap_t snap;
  logic [2:0]   idx;
  logic         pending;
  logic         byte_start;
  logic         byte_done;
  logic [7:0]   byte_data;

  assign snap      = '{flags: flag_s, count: count};
  assign byte_data = frm[idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fst        <= F_IDLE;
      frm        <= '0;
      idx        <= '0;
      pending    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      byte_start <= 1'b0;
    end else begin
      pending    <= pending | trig;
      frame_done <= 1'b0;
      byte_start <= 1'b0;
      case (fst)
        F_IDLE: begin
          if (pending) begin
            busy <= 1'b1;
            fst  <= F_LOAD;
          end
        end
        F_LOAD: begin
          // A trigger landing on this cycle must survive the clear
          pending    <= trig;
          frm        <= build_frame(snap);
          idx        <= '0;
          byte_start <= 1'b1;
          fst        <= F_SEND;
        end
        F_SEND: fst <= F_WAIT;
        F_WAIT: begin
          if (byte_done) begin
            if (idx == 3'(FRAME_LEN - 1)) begin
              busy       <= 1'b0;
              frame_done <= 1'b1;
              fst        <= F_DONE;
            end else begin
              idx        <= idx + 1'b1;
              byte_start <= 1'b1;
              fst        <= F_SEND;
            end
          end
        end
        F_DONE:  fst <= F_IDLE;
        default: fst <= F_IDLE;
      endcase
    end
  end

  uart_tx_byte #(.DIV(DIV)) u_byte (
    .clk   (clk),
    .reset (reset),
    .start (byte_start),
    .data  (byte_data),
    .tx    (tx),
    .done  (byte_done)
  );

endmodule
